// File: rtl/nts_api.sv
// nts_api: host register bus decoder for the NTS blocks.
// Splits the 12-bit host address space into per-block chip-selects,
// a shared block-relative address and write strobe, and returns the
// selected block's read data combinationally. A single flop flags
// host accesses that hit no block.
module nts_api (
  input  logic        i_clk,
  input  logic        i_areset,

  input  logic        i_external_api_cs,
  input  logic        i_external_api_we,
  input  logic [11:0] i_external_api_address,
  input  logic [31:0] i_external_api_write_data,
  output logic [31:0] o_external_api_read_data,
  output logic        o_external_api_error,

  output logic        o_internal_api_we,
  output logic [7:0]  o_internal_api_address,
  output logic [31:0] o_internal_api_write_data,

  output logic        o_internal_engine_api_cs,
  input  logic [31:0] i_internal_engine_api_read_data,
  output logic        o_internal_clock_api_cs,
  input  logic [31:0] i_internal_clock_api_read_data,
  output logic        o_internal_cookie_api_cs,
  input  logic [31:0] i_internal_cookie_api_read_data,
  output logic        o_internal_keymem_api_cs,
  input  logic [31:0] i_internal_keymem_api_read_data,
  output logic        o_internal_debug_api_cs,
  input  logic [31:0] i_internal_debug_api_read_data
);

  typedef enum logic [2:0] {
    BLK_NONE,
    BLK_ENGINE,
    BLK_CLOCK,
    BLK_COOKIE,
    BLK_KEYMEM,
    BLK_DEBUG
  } block_e;

  block_e      sel;
  logic [11:0] base;
  logic [11:0] offset;
  logic        unmapped;

  // Address decode: pick the one block whose range holds the host address.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    sel  = BLK_NONE;
    base = 12'h000;
    if (i_external_api_cs) begin
      if (i_external_api_address[11:4] == 8'h00) begin
        sel  = BLK_ENGINE;
        base = 12'h000;
      end else if (i_external_api_address[11:4] == 8'h01) begin
        sel  = BLK_CLOCK;
        base = 12'h010;
      end else if (i_external_api_address[11:4] == 8'h02) begin
        sel  = BLK_COOKIE;
        base = 12'h020;
      end else if (i_external_api_address[11:5] == 7'h04) begin
        sel  = BLK_KEYMEM;
        base = 12'h080;
      end else if (i_external_api_address[11:4] == 8'h0A) begin
        sel  = BLK_DEBUG;
        base = 12'h0A0;
      end
    end
  end

  assign offset   = i_external_api_address - base;
  assign unmapped = i_external_api_cs && (sel == BLK_NONE);

  // Fan-out to the blocks: one-hot chip-selects and the shared strobe/address.
  always_comb begin
    o_internal_engine_api_cs = (sel == BLK_ENGINE);
    o_internal_clock_api_cs  = (sel == BLK_CLOCK);
    o_internal_cookie_api_cs = (sel == BLK_COOKIE);
    o_internal_keymem_api_cs = (sel == BLK_KEYMEM);
    o_internal_debug_api_cs  = (sel == BLK_DEBUG);
    o_internal_api_we        = i_external_api_we && (sel != BLK_NONE);
    o_internal_api_address   = (sel != BLK_NONE) ? offset[7:0] : 8'h00;
  end

  assign o_internal_api_write_data = i_external_api_write_data;

  // Read mux: return only the selected block's data, zero otherwise.
  always_comb begin
    o_external_api_read_data = 32'h0;
    unique case (sel)
      BLK_ENGINE: o_external_api_read_data = i_internal_engine_api_read_data;
      BLK_CLOCK:  o_external_api_read_data = i_internal_clock_api_read_data;
      BLK_COOKIE: o_external_api_read_data = i_internal_cookie_api_read_data;
      BLK_KEYMEM: o_external_api_read_data = i_internal_keymem_api_read_data;
      BLK_DEBUG:  o_external_api_read_data = i_internal_debug_api_read_data;
      default:    o_external_api_read_data = 32'h0;
    endcase
  end

  // Error flag: one-cycle pulse after each unmapped host access.
  always_ff @(posedge i_clk or posedge i_areset) begin
    // NOTE: flops use non-blocking assignment so every register samples
    // pre-edge values regardless of block evaluation order.
    if (i_areset) o_external_api_error <= 1'b0;
    else          o_external_api_error <= unmapped;
  end

endmodule

// File: tb/tb_nts_api.sv
// tb_nts_api: directed test of the nts_api decoder against a range-table
// model, with literal expectations on the key vectors.
module tb_nts_api;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_cs, ext_we;
  logic [11:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_err;
  logic        int_we;
  logic [7:0]  int_addr;
  logic [31:0] int_wdata;
  logic [4:0]  cs_vec;   // {engine, clock, cookie, keymem, debug}
  logic [31:0] rd [5];
  logic        run = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nts_api dut (
    .i_clk                           (clk),
    .i_areset                        (rst),
    .i_external_api_cs               (ext_cs),
    .i_external_api_we               (ext_we),
    .i_external_api_address          (ext_addr),
    .i_external_api_write_data       (ext_wdata),
    .o_external_api_read_data        (ext_rdata),
    .o_external_api_error            (ext_err),
    .o_internal_api_we               (int_we),
    .o_internal_api_address          (int_addr),
    .o_internal_api_write_data       (int_wdata),
    .o_internal_engine_api_cs        (cs_vec[4]),
    .i_internal_engine_api_read_data (rd[0]),
    .o_internal_clock_api_cs         (cs_vec[3]),
    .i_internal_clock_api_read_data  (rd[1]),
    .o_internal_cookie_api_cs        (cs_vec[2]),
    .i_internal_cookie_api_read_data (rd[2]),
    .o_internal_keymem_api_cs        (cs_vec[1]),
    .i_internal_keymem_api_read_data (rd[3]),
    .o_internal_debug_api_cs         (cs_vec[0]),
    .i_internal_debug_api_read_data  (rd[4])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: block index 0..4 from the address map, -1 when unmapped.
  function automatic int blk_of(input logic [11:0] a);
    if (a <= 12'h00F)                   return 0;
    if (a >= 12'h010 && a <= 12'h01F)   return 1;
    if (a >= 12'h020 && a <= 12'h02F)   return 2;
    if (a >= 12'h080 && a <= 12'h09F)   return 3;
    if (a >= 12'h0A0 && a <= 12'h0AF)   return 4;
    return -1;
  endfunction

  function automatic logic [11:0] base_of(input int b);
    case (b)
      0:       return 12'h000;
      1:       return 12'h010;
      2:       return 12'h020;
      3:       return 12'h080;
      default: return 12'h0A0;
    endcase
  endfunction

  // Model of the error flag: an unmapped access seen at an edge shows next cycle.
  logic model_err;
  always @(posedge clk or posedge rst) begin
    if (rst) model_err <= 1'b0;
    else     model_err <= ext_cs && (blk_of(ext_addr) < 0);
  end

  // Compare every output with the model once per cycle, away from the edge.
  int          m_blk;
  logic [4:0]  m_cs;
  logic [7:0]  m_addr;
  logic [31:0] m_rdata;
  logic [11:0] m_diff;
  always @(negedge clk) begin
    if (run) begin
      m_blk   = ext_cs ? blk_of(ext_addr) : -1;
      m_cs    = 5'b0;
      m_addr  = 8'h00;
      m_rdata = 32'h0;
      if (m_blk >= 0) begin
        m_cs[4 - m_blk] = 1'b1;
        m_diff  = ext_addr - base_of(m_blk);
        m_addr  = m_diff[7:0];
        m_rdata = rd[m_blk];
      end
      check("model cs",    {27'b0, cs_vec}, {27'b0, m_cs});
      check("model addr",  {24'b0, int_addr}, {24'b0, m_addr});
      check("model we",    {31'b0, int_we}, {31'b0, ext_we && (m_blk >= 0)});
      check("model wdata", int_wdata, ext_wdata);
      check("model rdata", ext_rdata, m_rdata);
      check("model err",   {31'b0, ext_err}, {31'b0, model_err});
    end
  end

  // Drive one host vector just after an edge, then wait to mid-cycle.
  task automatic apply(input logic cs, input logic we, input logic [11:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    ext_cs    = cs;
    ext_we    = we;
    ext_addr  = a;
    ext_wdata = wd;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ext_cs = 1'b0; ext_we = 1'b0; ext_addr = 12'h0; ext_wdata = 32'h0;
    rd[0] = 32'hE001_2345; rd[1] = 32'hC10C_0001; rd[2] = 32'hC00C_1E02;
    rd[3] = 32'hCEE7_0003; rd[4] = 32'hDEB0_0004;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset err", {31'b0, ext_err}, 32'h0);
    rst = 1'b0;

    // Idle with we asserted must leave everything quiet.
    apply(1'b0, 1'b1, 12'h005, 32'h1234_5678);
    check("idle cs",    {27'b0, cs_vec}, 32'h0);
    check("idle rdata", ext_rdata, 32'h0);
    check("idle we",    {31'b0, int_we}, 32'h0);

    apply(1'b1, 1'b0, 12'h005, 32'h0);
    check("engine cs",    {27'b0, cs_vec}, 32'h10);
    check("engine addr",  {24'b0, int_addr}, 32'h05);
    check("engine rdata", ext_rdata, 32'hE001_2345);

    apply(1'b1, 1'b0, 12'h010, 32'hF);
    check("clock cs",    {27'b0, cs_vec}, 32'h08);
    check("clock addr",  {24'b0, int_addr}, 32'h00);
    check("clock wdata", int_wdata, 32'h0000_000F);
    check("clock rdata", ext_rdata, 32'hC10C_0001);

    apply(1'b1, 1'b1, 12'h023, 32'h9);
    check("cookie cs",   {27'b0, cs_vec}, 32'h04);
    check("cookie addr", {24'b0, int_addr}, 32'h03);
    check("cookie we",   {31'b0, int_we}, 32'h1);

    apply(1'b1, 1'b1, 12'h082, 32'hE);
    check("keymem cs",   {27'b0, cs_vec}, 32'h02);
    check("keymem addr", {24'b0, int_addr}, 32'h02);

    apply(1'b1, 1'b1, 12'h0AF, 32'hD);
    check("debug cs",   {27'b0, cs_vec}, 32'h01);
    check("debug addr", {24'b0, int_addr}, 32'h0F);
    check("debug we",   {31'b0, int_we}, 32'h1);

    // Mapped range edges; read data changes to show the mux tracks inputs.
    rd[0] = 32'h0BAD_F00D;
    apply(1'b1, 1'b0, 12'h00F, 32'h0);
    check("edge 00F addr",  {24'b0, int_addr}, 32'h0F);
    check("edge 00F rdata", ext_rdata, 32'h0BAD_F00D);
    apply(1'b1, 1'b0, 12'h09F, 32'h0);
    check("edge 09F cs",   {27'b0, cs_vec}, 32'h02);
    check("edge 09F addr", {24'b0, int_addr}, 32'h1F);
    apply(1'b1, 1'b0, 12'h0A0, 32'h0);
    check("edge 0A0 cs", {27'b0, cs_vec}, 32'h01);

    // Unmapped access: no selects, then a one-cycle error pulse.
    apply(1'b1, 1'b1, 12'h050, 32'hAA);
    check("unmapped cs",    {27'b0, cs_vec}, 32'h0);
    check("unmapped rdata", ext_rdata, 32'h0);
    check("unmapped we",    {31'b0, int_we}, 32'h0);
    check("unmapped addr",  {24'b0, int_addr}, 32'h0);
    check("unmapped err0",  {31'b0, ext_err}, 32'h0);
    apply(1'b0, 1'b0, 12'h050, 32'h0);
    check("err pulse high", {31'b0, ext_err}, 32'h1);
    apply(1'b0, 1'b0, 12'h000, 32'h0);
    check("err pulse low", {31'b0, ext_err}, 32'h0);

    // Back-to-back unmapped edges hold the flag high.
    apply(1'b1, 1'b0, 12'h030, 32'h0);
    apply(1'b1, 1'b0, 12'h07F, 32'h0);
    check("b2b err 1", {31'b0, ext_err}, 32'h1);
    apply(1'b1, 1'b0, 12'h0B0, 32'h0);
    check("b2b err 2", {31'b0, ext_err}, 32'h1);
    apply(1'b1, 1'b0, 12'hFFF, 32'h0);
    check("b2b err 3", {31'b0, ext_err}, 32'h1);
    check("fff cs", {27'b0, cs_vec}, 32'h0);
    apply(1'b0, 1'b0, 12'h000, 32'h0);
    check("b2b err tail", {31'b0, ext_err}, 32'h1);
    apply(1'b0, 1'b0, 12'h000, 32'h0);
    check("b2b err clear", {31'b0, ext_err}, 32'h0);

    // Reset in the middle of an error pulse.
    apply(1'b1, 1'b0, 12'h050, 32'h0);
    @(posedge clk);
    #1;
    check("pre-reset err", {31'b0, ext_err}, 32'h1);
    rst = 1'b1;
    #1;
    check("reset clears err", {31'b0, ext_err}, 32'h0);
    ext_addr = 12'h005;
    #1;
    check("reset comb cs", {27'b0, cs_vec}, 32'h10);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(1'b0, 1'b0, 12'h000, 32'h0);
    check("post-reset err", {31'b0, ext_err}, 32'h0);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
